// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the 5-stage MIPS pipeline.
// A LOAD/RUN state machine keeps the word-write load port and the registered
// fetch path mutually exclusive. Fetches support freeze (stall) and flush
// (squash to NOP), and flag out-of-range or misaligned addresses.
module instr_mem_loadable #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_we,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              freeze,
  input  logic              flush,
  output logic              ready,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              fetch_err,
  output logic              load_err
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so the range compares never truncate DEPTH.
  localparam logic [IDX_W:0]  DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] fetch_word;
  logic              fetch_bad;
  logic              load_oob;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  // Address decode, range checks and memory read port.
  always_comb begin
    fetch_word = fetch_addr >> 2;
    // Full-width compare: addresses beyond the memory are errors, never aliases.
    fetch_bad  = (fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_word} >= DEPTH_A);
    load_oob   = ({1'b0, load_idx} >= DEPTH_L);
    wr_en      = (state == S_LOAD) && load_we && !load_oob;
    rd_data    = mem[fetch_word[MEM_AW-1:0]];
  end

  // Memory array write; deliberately not reset so contents survive resets.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[load_idx[MEM_AW-1:0]] <= load_data;
    end
  end

  // LOAD/RUN state machine with registered status and fetch outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_LOAD;
      ready      <= 1'b0;
      load_err   <= 1'b0;
      inst_out   <= '0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_we && load_oob) begin
            load_err <= 1'b1;
          end
          if (load_done) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (load_start) begin
            state    <= S_LOAD;
            ready    <= 1'b0;
            load_err <= 1'b0;
          end
        end
        default: begin
          state <= S_LOAD;
          ready <= 1'b0;
        end
      endcase

      if (flush) begin
        inst_out   <= '0;
        inst_valid <= 1'b0;
        fetch_err  <= 1'b0;
      end else if (freeze) begin
        inst_out   <= inst_out;
        inst_valid <= inst_valid;
        fetch_err  <= fetch_err;
      end else if ((state == S_RUN) && fetch_req) begin
        inst_out   <= fetch_bad ? '0 : rd_data;
        inst_valid <= 1'b1;
        fetch_err  <= fetch_bad;
      end else begin
        inst_out   <= '0;
        inst_valid <= 1'b0;
        fetch_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed self-checking bench for instr_mem_loadable (DEPTH=256, IDX_W=9 so
// out-of-range load indices can be expressed).
module tb_instr_mem_loadable;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        load_we;
  logic [8:0]  load_idx;
  logic [31:0] load_data;
  logic        load_done;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        freeze;
  logic        flush;
  logic        ready;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        fetch_err;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  instr_mem_loadable #(
    .DATA_W(32),
    .DEPTH (256),
    .ADDR_W(32),
    .IDX_W (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .load_we   (load_we),
    .load_idx  (load_idx),
    .load_data (load_data),
    .load_done (load_done),
    .fetch_req (fetch_req),
    .fetch_addr(fetch_addr),
    .freeze    (freeze),
    .flush     (flush),
    .ready     (ready),
    .inst_out  (inst_out),
    .inst_valid(inst_valid),
    .fetch_err (fetch_err),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [8:0] idx, input logic [31:0] data);
    load_we = 1'b1; load_idx = idx; load_data = data;
    tick();
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_start = 0; load_we = 0; load_idx = '0; load_data = '0; load_done = 0;
    fetch_req = 0; fetch_addr = '0; freeze = 0; flush = 0;
    #2 rst = 1'b0;
    #1;
    if ({ready, inst_valid, fetch_err, load_err} !== 4'b0000 || inst_out !== 32'h0) begin
      $display("FAIL reset_async got rdy=%b v=%b fe=%b le=%b inst=%h exp all 0",
               ready, inst_valid, fetch_err, load_err, inst_out);
      errors++;
    end
    checks++;
    tick(); tick();
    rst = 1'b1;
    tick();
    if (ready !== 1'b0) begin
      $display("FAIL reset_state_load got ready=%b exp 0", ready);
      errors++;
    end
    checks++;
  endtask

  task automatic test_load_run();
    write_word(9'd0,   32'h8001060A);
    write_word(9'd1,   32'h04011000);
    write_word(9'd2,   32'h11112222);
    write_word(9'd255, 32'hCAFEF00D);
    // Fetch requests are ignored while loading.
    fetch_req = 1; fetch_addr = 32'h0;
    tick();
    if (inst_valid !== 1'b0 || ready !== 1'b0 || inst_out !== 32'h0) begin
      $display("FAIL load_gating got v=%b rdy=%b inst=%h exp v=0 rdy=0 inst=0",
               inst_valid, ready, inst_out);
      errors++;
    end
    checks++;
    // Fetch presented alongside load_done is still not honoured.
    load_done = 1;
    tick();
    load_done = 0;
    if (ready !== 1'b1 || inst_valid !== 1'b0) begin
      $display("FAIL load_done_edge got rdy=%b v=%b exp rdy=1 v=0", ready, inst_valid);
      errors++;
    end
    checks++;
    fetch_addr = 32'h0;
    tick();
    if (inst_out !== 32'h8001060A || inst_valid !== 1'b1 || fetch_err !== 1'b0) begin
      $display("FAIL fetch0 got inst=%h v=%b fe=%b exp 8001060A 1 0", inst_out, inst_valid, fetch_err);
      errors++;
    end
    checks++;
    fetch_addr = 32'h4;
    tick();
    if (inst_out !== 32'h04011000 || inst_valid !== 1'b1 || ready !== 1'b1) begin
      $display("FAIL fetch4 got inst=%h v=%b rdy=%b exp 04011000 1 1", inst_out, inst_valid, ready);
      errors++;
    end
    checks++;
    fetch_req = 0;
    tick();
    if (inst_out !== 32'h0 || inst_valid !== 1'b0) begin
      $display("FAIL idle_nop got inst=%h v=%b exp 0 0", inst_out, inst_valid);
      errors++;
    end
    checks++;
  endtask

  task automatic test_freeze_flush();
    fetch_req = 1; fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h4; freeze = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (inst_out !== 32'h8001060A || inst_valid !== 1'b1) begin
        $display("FAIL freeze_hold%0d got inst=%h v=%b exp 8001060A 1", i, inst_out, inst_valid);
        errors++;
      end
      checks++;
    end
    freeze = 0;
    tick();
    if (inst_out !== 32'h04011000) begin
      $display("FAIL freeze_release got inst=%h exp 04011000", inst_out);
      errors++;
    end
    checks++;
    fetch_addr = 32'h8;
    tick();
    if (inst_out !== 32'h11112222 || inst_valid !== 1'b1) begin
      $display("FAIL fetch8 got inst=%h v=%b exp 11112222 1", inst_out, inst_valid);
      errors++;
    end
    checks++;
    freeze = 1; flush = 1;
    tick();
    if (inst_out !== 32'h0 || inst_valid !== 1'b0 || fetch_err !== 1'b0) begin
      $display("FAIL flush_over_freeze got inst=%h v=%b fe=%b exp 0 0 0", inst_out, inst_valid, fetch_err);
      errors++;
    end
    checks++;
    freeze = 0; flush = 0; fetch_req = 0;
    tick();
  endtask

  task automatic test_bad_addr();
    logic [31:0] addrs [6];
    logic [31:0] exp_inst [6];
    logic        exp_err [6];
    addrs = '{32'h402, 32'h3FC, 32'h400, 32'h1, 32'h4000_0000, 32'h4};
    exp_inst = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h04011000};
    exp_err = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    fetch_req = 1;
    for (int i = 0; i < 6; i++) begin
      fetch_addr = addrs[i];
      tick();
      if (inst_out !== exp_inst[i] || fetch_err !== exp_err[i] || inst_valid !== 1'b1) begin
        $display("FAIL bad_addr[%h] got inst=%h fe=%b v=%b exp %h %b 1",
                 addrs[i], inst_out, fetch_err, inst_valid, exp_inst[i], exp_err[i]);
        errors++;
      end
      checks++;
    end
    fetch_addr = 32'h400;
    tick();
    freeze = 1; fetch_addr = 32'h0;
    tick();
    if (fetch_err !== 1'b1 || inst_valid !== 1'b1 || inst_out !== 32'h0) begin
      $display("FAIL freeze_err_hold got fe=%b v=%b inst=%h exp 1 1 0", fetch_err, inst_valid, inst_out);
      errors++;
    end
    checks++;
    freeze = 0; fetch_req = 0;
    tick();
  endtask

  task automatic test_load_err();
    load_start = 1;
    tick();
    load_start = 0;
    if (ready !== 1'b0) begin
      $display("FAIL load_start_ready got %b exp 0", ready);
      errors++;
    end
    checks++;
    write_word(9'd300, 32'hFFFFFFFF);
    if (load_err !== 1'b1) begin
      $display("FAIL load_err_300 got %b exp 1", load_err);
      errors++;
    end
    checks++;
    write_word(9'd256, 32'hFFFFFFFF);
    load_done = 1;
    tick();
    load_done = 0;
    fetch_req = 1; fetch_addr = 32'h0;
    tick();
    if (inst_out !== 32'h8001060A || load_err !== 1'b1) begin
      $display("FAIL load_err_nowrite got inst=%h le=%b exp 8001060A 1", inst_out, load_err);
      errors++;
    end
    checks++;
    fetch_req = 0;
    load_start = 1;
    tick();
    load_start = 0;
    if (load_err !== 1'b0 || ready !== 1'b0) begin
      $display("FAIL load_err_clear got le=%b rdy=%b exp 0 0", load_err, ready);
      errors++;
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    // Write in the same cycle as load_done is still honoured.
    load_we = 1; load_idx = 9'd5; load_data = 32'hDEADBEEF; load_done = 1;
    tick();
    load_we = 0; load_done = 0;
    if (ready !== 1'b1) begin
      $display("FAIL done_with_we got ready=%b exp 1", ready);
      errors++;
    end
    checks++;
    fetch_req = 1; fetch_addr = 32'd20;
    tick();
    fetch_req = 0;
    if (inst_out !== 32'hDEADBEEF || inst_valid !== 1'b1) begin
      $display("FAIL fetch20 got inst=%h v=%b exp DEADBEEF 1", inst_out, inst_valid);
      errors++;
    end
    checks++;
    load_start = 1; load_done = 1;
    tick();
    if (ready !== 1'b0) begin
      $display("FAIL both_in_run got ready=%b exp 0", ready);
      errors++;
    end
    checks++;
    tick();
    load_start = 0; load_done = 0;
    if (ready !== 1'b1) begin
      $display("FAIL both_in_load got ready=%b exp 1", ready);
      errors++;
    end
    checks++;
  endtask

  task automatic test_reset_mid_run();
    fetch_req = 1; fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h4;
    #2 rst = 1'b0;
    #1;
    if ({ready, inst_valid, fetch_err, load_err} !== 4'b0000 || inst_out !== 32'h0) begin
      $display("FAIL reset_mid_run got rdy=%b v=%b fe=%b le=%b inst=%h exp all 0",
               ready, inst_valid, fetch_err, load_err, inst_out);
      errors++;
    end
    checks++;
    tick();
    rst = 1'b1;
    fetch_addr = 32'h0;
    tick();
    if (inst_valid !== 1'b0 || ready !== 1'b0) begin
      $display("FAIL reset_to_load got v=%b rdy=%b exp 0 0", inst_valid, ready);
      errors++;
    end
    checks++;
    load_done = 1;
    tick();
    load_done = 0;
    tick();
    if (inst_out !== 32'h8001060A || inst_valid !== 1'b1) begin
      $display("FAIL mem_persist got inst=%h v=%b exp 8001060A 1", inst_out, inst_valid);
      errors++;
    end
    checks++;
    fetch_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_freeze_flush();
    test_bad_addr();
    test_load_err();
    test_simultaneous();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
